// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-stage SRAM controller.
// The FSM encoding is also what the controller exposes on its debug state output.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC_LO = 2'd1,
      ACC_HI = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

   localparam int DEF_SRAM_ADDR_W = 18;
   localparam int DEF_WAIT_CYCLES = 1;

endpackage

// File: rtl/mem_sram_ctrl.sv
// Splits a 32-bit pipeline load/store into two timed 16-bit asynchronous SRAM accesses.
// Optional one-entry read cache is enabled by defining MEM_RCACHE_EN.
module mem_sram_ctrl
   import mem_pkg::*;
#(
   parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W,
   parameter int SRAM_DATA_W = 16,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_r,
   input  logic                   mem_w,
   input  logic [31:0]            address,
   input  logic [31:0]            wdata,
   output logic [31:0]            rdata,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_dq_o,
   input  logic [SRAM_DATA_W-1:0] sram_dq_i,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n,
   output logic [1:0]             dbg_state
);

   localparam int         WIDX_W = SRAM_ADDR_W - 1;
   localparam logic [3:0] LAST   = 4'(WAIT_CYCLES);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;
   logic [31:0]         r_rdata;

   logic [WIDX_W-1:0]   w_widx;
   logic                w_req;
   logic                w_is_wr;
   logic                w_is_rd;
   logic                w_acc;
   logic                w_half;
   logic                w_last;
   logic                w_hit;
   logic                w_unused;

   // Byte offset and bits above the SRAM reach are intentionally dropped.
   assign w_widx   = address[SRAM_ADDR_W:2];
   assign w_unused = ^{address[31:SRAM_ADDR_W+1], address[1:0]};

   // A simultaneous read+write request is treated as a write.
   assign w_req   = mem_r | mem_w;
   assign w_is_wr = mem_w;
   assign w_is_rd = mem_r & ~mem_w;

   assign w_acc  = (r_state == ACC_LO) || (r_state == ACC_HI);
   assign w_half = (r_state == ACC_HI) ? HALF_HI : HALF_LO;
   assign w_last = (r_cnt == LAST);

`ifdef MEM_RCACHE_EN
   logic                r_c_valid;
   logic [WIDX_W-1:0]   r_c_tag;
   logic [31:0]         r_c_data;

   assign w_hit = w_is_rd && r_c_valid && (r_c_tag == w_widx);

   // Filled from the completed read; writes to the cached word keep it coherent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_c_valid <= 1'b0;
         r_c_tag   <= '0;
         r_c_data  <= '0;
      end else if (r_state == DONE) begin
         if (w_is_rd) begin
            r_c_valid <= 1'b1;
            r_c_tag   <= w_widx;
            r_c_data  <= r_rdata;
         end else if (w_is_wr && r_c_valid && (r_c_tag == w_widx)) begin
            r_c_data  <= wdata;
         end
      end
   end
`else
   assign w_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_req) w_state_nxt = w_hit ? DONE : ACC_LO;
         ACC_LO:  if (w_last) w_state_nxt = ACC_HI;
         ACC_HI:  if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      // The wait counter restarts from zero on every state change.
      w_cnt_nxt = '0;
      if (w_acc && (w_state_nxt == r_state)) w_cnt_nxt = r_cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
      end else if (w_acc && w_is_rd && w_last) begin
         if (w_half == HALF_HI) r_rdata[31:16] <= sram_dq_i;
         else                   r_rdata[15:0]  <= sram_dq_i;
      end
`ifdef MEM_RCACHE_EN
      else if ((r_state == IDLE) && w_hit) begin
         r_rdata <= r_c_data;
      end
`endif
   end

   always_comb begin
      ready      = 1'b0;
      sram_addr  = '0;
      sram_dq_o  = '0;
      sram_dq_oe = 1'b0;
      sram_we_n  = 1'b1;
      if (r_state == IDLE)      ready = rst & ~w_req;
      else if (r_state == DONE) ready = rst;
      if (w_acc) begin
         sram_addr = {w_widx, w_half};
         if (w_is_wr) begin
            sram_dq_oe = 1'b1;
            sram_dq_o  = (w_half == HALF_HI) ? wdata[31:16] : wdata[15:0];
            // Strobe released in the final cycle so data is held across the rising edge.
            sram_we_n  = ~(r_cnt < LAST);
         end
      end
   end

   assign rdata     = r_rdata;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a behavioural 16-bit SRAM; second instance uses WAIT_CYCLES=3.
// Cache-specific expectations switch on MEM_RCACHE_EN.
module tb_mem_sram_ctrl;
   import mem_pkg::*;

   localparam int AW = 18;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT 1 (WAIT_CYCLES = 1) ----------------
   logic          mem_r = 1'b0, mem_w = 1'b0;
   logic [31:0]   address = '0, wdata = '0;
   logic [31:0]   rdata;
   logic          ready;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_o, sram_dq_i;
   logic          sram_dq_oe, sram_we_n;
   logic [1:0]    dbg_state;

   mem_sram_ctrl #(.SRAM_ADDR_W(AW), .SRAM_DATA_W(16), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w), .address(address), .wdata(wdata),
      .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
      .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .dbg_state(dbg_state)
   );

   // Behavioural async SRAM: combinational read, write on the rising edge of the strobe.
   logic [15:0] sram_mem [0:(1<<AW)-1];
   assign sram_dq_i = sram_mem[sram_addr];
   always @(posedge sram_we_n) if (rst === 1'b1) sram_mem[sram_addr] <= sram_dq_o;

   // ---------------- DUT 2 (WAIT_CYCLES = 3) ----------------
   logic          mem_r2 = 1'b0, mem_w2 = 1'b0;
   logic [31:0]   address2 = '0, wdata2 = '0;
   logic [31:0]   rdata2;
   logic          ready2;
   logic [AW-1:0] sram_addr2;
   logic [15:0]   sram_dq_o2;
   logic [15:0]   sram_dq_i2 = 16'h0000;
   logic          sram_dq_oe2, sram_we_n2;
   logic [1:0]    dbg_state2;

   mem_sram_ctrl #(.SRAM_ADDR_W(AW), .SRAM_DATA_W(16), .WAIT_CYCLES(3)) dut2 (
      .clk(clk), .rst(rst), .mem_r(mem_r2), .mem_w(mem_w2), .address(address2), .wdata(wdata2),
      .rdata(rdata2), .ready(ready2), .sram_addr(sram_addr2), .sram_dq_o(sram_dq_o2),
      .sram_dq_i(sram_dq_i2), .sram_dq_oe(sram_dq_oe2), .sram_we_n(sram_we_n2), .dbg_state(dbg_state2)
   );

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_rdata(input string tag);
      logic [31:0] e;
      e = exp_q.pop_front();
      chk(tag, rdata, e);
   endtask

   // ---------------- driver tasks ----------------
   // Issues a request in cycle 0 and holds it until ready is seen; inputs stay applied on return.
   task automatic run_req(input logic i_r, input logic i_w, input logic [31:0] i_a,
                          input logic [31:0] i_d, output int lat, output int we_lo,
                          output int act, output int done_cyc,
                          output logic [31:0] a_lo, output logic [31:0] a_hi);
      @(posedge clk); #1;
      mem_r = i_r; mem_w = i_w; address = i_a; wdata = i_d;
      lat = -1; we_lo = 0; act = 0; done_cyc = 0; a_lo = '0; a_hi = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready) begin
            lat = c;
            done_cyc = cyc;
            break;
         end
         if (!sram_we_n) we_lo++;
         if (sram_addr != '0) act++;
         if (c == 1) a_lo = 32'(sram_addr);
         if (c == 3) a_hi = 32'(sram_addr);
         @(posedge clk); #1;
      end
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      mem_r = 1'b0; mem_w = 1'b0;
   endtask

   int          lat, we_lo, act, d1, d2;
   logic [31:0] a_lo, a_hi;
   int          lat2, we_a, we_b;
   logic [15:0] dq_first, dq_second;

`ifdef MEM_RCACHE_EN
   localparam int HIT_LAT = 1;
   localparam int HIT_ACT = 0;
`else
   localparam int HIT_LAT = 5;
   localparam int HIT_ACT = 4;
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      sram_mem[8]  = 16'h1111; sram_mem[9]  = 16'h2222;
      sram_mem[10] = 16'h3333; sram_mem[11] = 16'h4444;
      sram_mem[16] = 16'h5A5A; sram_mem[17] = 16'hA5A5;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'h0);
      chk("rst_dq_o", 32'(sram_dq_o), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      rst = 1'b1;
      #1;
      chk("idle_ready", 32'(ready), 32'd1);

      // Write 0xDEADBEEF to 0x404
      run_req(1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, lat, we_lo, act, d1, a_lo, a_hi);
      chk("wr_lat", 32'(lat), 32'd5);
      chk("wr_we_lo", 32'(we_lo), 32'd2);
      chk("wr_addr_lo", a_lo, 32'h202);
      chk("wr_addr_hi", a_hi, 32'h203);
      chk("wr_mem_lo", 32'(sram_mem[18'h202]), 32'h0000_BEEF);
      chk("wr_mem_hi", 32'(sram_mem[18'h203]), 32'h0000_DEAD);
      go_idle();

      // Read it back
      exp_q.push_back(32'hDEAD_BEEF);
      run_req(1'b1, 1'b0, 32'h0000_0404, 32'h0, lat, we_lo, act, d1, a_lo, a_hi);
      chk("rd_lat", 32'(lat), 32'd5);
      chk("rd_we_lo", 32'(we_lo), 32'd0);
      chk_rdata("rd_data");
      go_idle();

      // Repeat read: cache hit when enabled, full sequence otherwise
      exp_q.push_back(32'hDEAD_BEEF);
      run_req(1'b1, 1'b0, 32'h0000_0404, 32'h0, lat, we_lo, act, d1, a_lo, a_hi);
      chk("rerd_lat", 32'(lat), 32'(HIT_LAT));
      chk("rerd_act", 32'(act), 32'(HIT_ACT));
      chk_rdata("rerd_data");
      go_idle();

      // Overwrite the same word, then read: the cached copy must follow
      run_req(1'b0, 1'b1, 32'h0000_0404, 32'h0BAD_F00D, lat, we_lo, act, d1, a_lo, a_hi);
      chk("wr2_lat", 32'(lat), 32'd5);
      go_idle();
      exp_q.push_back(32'h0BAD_F00D);
      run_req(1'b1, 1'b0, 32'h0000_0404, 32'h0, lat, we_lo, act, d1, a_lo, a_hi);
      chk("rd2_lat", 32'(lat), 32'(HIT_LAT));
      chk_rdata("rd2_data");
      go_idle();

      // Read and write together: write wins, rdata untouched
      run_req(1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, lat, we_lo, act, d1, a_lo, a_hi);
      chk("both_lat", 32'(lat), 32'd5);
      chk("both_we_lo", 32'(we_lo), 32'd2);
      chk("both_mem_lo", 32'(sram_mem[18'h4]), 32'h0000_5678);
      chk("both_mem_hi", 32'(sram_mem[18'h5]), 32'h0000_1234);
      chk("both_rdata", rdata, 32'h0BAD_F00D);
      go_idle();

      // Back-to-back reads
      exp_q.push_back(32'h2222_1111);
      exp_q.push_back(32'h4444_3333);
      run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, we_lo, act, d1, a_lo, a_hi);
      chk("b2b1_we_lo", 32'(we_lo), 32'd0);
      chk_rdata("b2b1_data");
      run_req(1'b1, 1'b0, 32'h0000_0014, 32'h0, lat, we_lo, act, d2, a_lo, a_hi);
      chk("b2b2_we_lo", 32'(we_lo), 32'd0);
      chk_rdata("b2b2_data");
      chk("b2b_gap", 32'(d2 - d1), 32'd6);
      go_idle();

      // Reset in ACC_HI of a read
      @(posedge clk); #1;
      mem_r = 1'b1; mem_w = 1'b0; address = 32'h0000_0020;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mid_state", 32'(dbg_state), 32'(ACC_HI));
      rst = 1'b0;
      mem_r = 1'b0;
      #1;
      chk("mid_rdata", rdata, 32'h0);
      chk("mid_we_n", 32'(sram_we_n), 32'd1);
      chk("mid_oe", 32'(sram_dq_oe), 32'd0);
      chk("mid_ready", 32'(ready), 32'd0);
      chk("mid_addr", 32'(sram_addr), 32'h0);
      chk("mid_state_rst", 32'(dbg_state), 32'(IDLE));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post_state", 32'(dbg_state), 32'(IDLE));
      chk("post_ready", 32'(ready), 32'd1);
      exp_q.push_back(32'hA5A5_5A5A);
      run_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, we_lo, act, d1, a_lo, a_hi);
      chk("post_lat", 32'(lat), 32'd5);
      chk_rdata("post_data");
      go_idle();
      // Word 0x14 was the last fill before reset, so it must now miss
      exp_q.push_back(32'h4444_3333);
      run_req(1'b1, 1'b0, 32'h0000_0014, 32'h0, lat, we_lo, act, d1, a_lo, a_hi);
      chk("post_miss_lat", 32'(lat), 32'd5);
      chk_rdata("post_miss_data");
      go_idle();

      // WAIT_CYCLES = 3 write
      @(posedge clk); #1;
      mem_w2 = 1'b1; address2 = 32'h0000_0404; wdata2 = 32'h89AB_CDEF;
      lat2 = -1; we_a = 0; we_b = 0; dq_first = '0; dq_second = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready2) begin
            lat2 = c;
            break;
         end
         if (!sram_we_n2 && c >= 1 && c <= 4) we_a++;
         if (!sram_we_n2 && c >= 5 && c <= 8) we_b++;
         if (c == 1) dq_first = sram_dq_o2;
         if (c == 5) dq_second = sram_dq_o2;
         @(posedge clk); #1;
      end
      chk("w3_lat", 32'(lat2), 32'd9);
      chk("w3_we_lo_a", 32'(we_a), 32'd3);
      chk("w3_we_lo_b", 32'(we_b), 32'd3);
      chk("w3_dq_lo", 32'(dq_first), 32'h0000_CDEF);
      chk("w3_dq_hi", 32'(dq_second), 32'h0000_89AB);
      @(posedge clk); #1;
      mem_w2 = 1'b0;
      @(negedge clk);
      chk("w3_idle_ready", 32'(ready2), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
